serial_sub: RTL and testbench



---
 rtl/serial_sub.sv | 98 +++++++++
 tb/tb_serial_sub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: {o_c, o_s} = i_a - i_b - i_c, one bit per clock, LSB first.
// Operands captured on an upstream handshake; result held until downstream accepts.
module serial_sub #(
   parameter int BW_DATA = 4
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [BW_DATA-1:0] i_a,
   input  logic [BW_DATA-1:0] i_b,
   input  logic               i_c,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [BW_DATA-1:0] o_s,
   output logic               o_c
);

   localparam int CW = $clog2(BW_DATA + 1);
   localparam logic [CW-1:0] LAST = CW'(BW_DATA - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [BW_DATA-1:0] a_sh, b_sh, res, res_nxt;
   logic [CW-1:0]      cnt;
   logic               borrow, borrow_nxt, d, last;

   assign o_ready = (state == IDLE);
   assign last    = (cnt == LAST);

   // full-subtractor bit slice on the current LSBs
   assign d          = a_sh[0] ^ b_sh[0] ^ borrow;
   assign borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
   assign res_nxt    = (res >> 1) | (BW_DATA'(d) << (BW_DATA - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (i_valid) state_nxt = CALC;
         CALC: if (last) state_nxt = DONE;
         DONE: if (i_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res     <= '0;
         borrow  <= 1'b0;
         cnt     <= '0;
         o_s     <= '0;
         o_c     <= 1'b0;
         o_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  a_sh   <= i_a;
                  b_sh   <= i_b;
                  borrow <= i_c;
                  res    <= '0;
                  cnt    <= '0;
               end
            end
            CALC: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res    <= res_nxt;
               borrow <= borrow_nxt;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  o_s     <= res_nxt;
                  o_c     <= borrow_nxt;
                  o_valid <= 1'b1;
               end
            end
            DONE: begin
               if (i_ready) o_valid <= 1'b0;
            end
            default: o_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: expected results queued at capture,
// compared when the result handshake completes.
module tb_serial_sub;

   localparam int BW = 4;

   logic          i_clk, i_rstn, i_valid, o_ready;
   logic [BW-1:0] i_a, i_b, o_s;
   logic          i_c, o_valid, i_ready, o_c;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   bit rnd_rdy = 0;
   logic [BW:0] q[$];

   logic          hold = 0;
   logic [BW-1:0] hs;
   logic          hc;

   serial_sub #(.BW_DATA(BW)) dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_b     (i_b),
      .i_c     (i_c),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_s     (o_s),
      .o_c     (o_c)
   );

   initial begin
      i_clk = 0;
      forever #5 i_clk = ~i_clk;
   end

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // random downstream stalls
   initial forever begin
      @(posedge i_clk);
      #1;
      if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
   end

   // monitor: sampled mid-cycle, inputs are stable for the next edge
   initial forever begin
      @(negedge i_clk);
      if (i_rstn) begin
         if (hold) begin
            chk("hold_v", o_valid, 1);
            chk("hold_s", o_s, hs);
            chk("hold_c", o_c, hc);
         end
         if (o_valid) chk("busy_rdy", o_ready, 0);
         if (o_valid && i_ready) begin
            if (q.size() == 0) chk("spurious", o_valid, 0);
            else chk("res", {o_c, o_s}, q.pop_front());
         end
         if (i_valid && o_ready)
            q.push_back(({1'b0, i_a} - {1'b0, i_b} - {{BW{1'b0}}, i_c}));
         hold = o_valid && !i_ready;
         hs = o_s;
         hc = o_c;
      end else begin
         hold = 0;
      end
   end

   task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic c, output int at);
      int n;
      i_a = a;
      i_b = b;
      i_c = c;
      i_valid = 1;
      n = 0;
      while (!o_ready && n < 200) begin
         tick();
         n++;
      end
      if (!o_ready) chk("acc_to", o_ready, 1);
      tick();
      at = cyc;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   typedef struct { logic [3:0] a; logic [3:0] b; logic c; } op_t;
   op_t ops[5];

   initial begin
      int at, prev, n;
      i_rstn = 0; i_valid = 1; i_ready = 0;
      i_a = 4'hf; i_b = 4'h1; i_c = 1;
      tick();
      tick();
      chk("rst_v", o_valid, 0);
      chk("rst_s", o_s, 0);
      chk("rst_c", o_c, 0);
      chk("rst_rdy", o_ready, 1);
      i_valid = 0;
      i_rstn = 1;
      i_ready = 1;
      tick();

      // basic op and latency
      send(4'd7, 4'd3, 1'b0, at);
      i_valid = 0;
      tick(); tick(); tick();
      chk("lat_early", o_valid, 0);
      tick();
      chk("lat_v", o_valid, 1);
      chk("lat_s", o_s, 4);
      chk("lat_c", o_c, 0);
      tick();
      chk("post_v", o_valid, 0);
      chk("post_rdy", o_ready, 1);

      // borrow corners
      ops[0] = '{4'd3, 4'd7, 1'b0};
      ops[1] = '{4'd0, 4'd0, 1'b1};
      ops[2] = '{4'd15, 4'd15, 1'b1};
      ops[3] = '{4'd15, 4'd0, 1'b0};
      ops[4] = '{4'd8, 4'd8, 1'b0};
      foreach (ops[i]) begin
         send(ops[i].a, ops[i].b, ops[i].c, at);
         i_valid = 0;
         drain();
      end

      // backpressure
      i_ready = 0;
      send(4'd5, 4'd2, 1'b0, at);
      i_valid = 0;
      n = 0;
      while (!o_valid && n < 50) begin
         tick();
         n++;
      end
      chk("bp_seen", o_valid, 1);
      tick(); tick(); tick();
      i_ready = 1;
      drain();

      // input isolation during CALC
      send(4'd10, 4'd3, 1'b1, at);
      for (int i = 0; i < 4; i++) begin
         i_a = 4'($urandom);
         i_b = 4'($urandom);
         i_c = 1'($urandom);
         i_valid = 1'(i & 1);
         tick();
      end
      i_valid = 0;
      drain();

      // reset on the second CALC edge
      send(4'd6, 4'd1, 1'b0, at);
      i_valid = 0;
      tick();
      i_rstn = 0;
      tick();
      i_rstn = 1;
      q.delete();
      chk("mid_v", o_valid, 0);
      chk("mid_s", o_s, 0);
      chk("mid_c", o_c, 0);
      chk("mid_rdy", o_ready, 1);
      send(4'd9, 4'd4, 1'b1, at);
      i_valid = 0;
      drain();

      // back-to-back with i_valid held
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         send(4'($urandom), 4'($urandom), 1'($urandom), at);
         if (i > 0) chk("b2b_gap", at - prev, 6);
         prev = at;
      end
      i_valid = 0;
      drain();

      // exhaustive with random stalls
      rnd_rdy = 1;
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               send(4'(a), 4'(b), 1'(c), at);
      i_valid = 0;
      drain();
      rnd_rdy = 0;
      i_ready = 1;
      tick();
      chk("sb_left", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
